// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int XLEN   = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(
        input logic [XLEN-1:0] a
    );
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem request/response, redirect and decode channels.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [INST_W-1:0] id_inst;
    logic [XLEN-1:0]   id_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        output id_valid, id_inst, id_pc,
        input  imem_req_ready, imem_rsp_valid,
        input  imem_rsp_data, redirect_valid,
        input  redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  id_valid, id_inst, id_pc,
        output imem_req_ready, imem_rsp_valid,
        output imem_rsp_data, redirect_valid,
        output redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; used as the
// instruction buffer and as the in-flight PC queue.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    // a full buffer still takes a push when the head leaves
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push)
                           - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC ownership, credit-limited imem requests,
// in-order response buffering and redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   pcq_count;
    logic [CW:0]     used;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_keep;
    logic            id_fire;
    logic            buf_full;
    logic            buf_empty;
    logic            pcq_full;
    logic            pcq_empty;
    fetch_entry_t    buf_din;
    fetch_entry_t    buf_head;
    fetch_entry_t    pcq_din;
    fetch_entry_t    pcq_head;
    logic            unused_pcq;

    // credits cover both in-flight requests and buffered entries
    assign used      = {1'b0, outstanding} + {1'b0, buf_count};
    assign credit_ok = used < (CW+1)'(FIFO_DEPTH);

    assign bus.imem_req_valid = credit_ok
                              && !bus.redirect_valid
                              && !reset;
    assign bus.imem_req_addr  = pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep = bus.imem_rsp_valid && drop == '0
                    && !bus.redirect_valid;
    assign id_fire  = bus.id_valid && bus.id_ready
                    && !bus.redirect_valid;

    assign bus.id_valid = !buf_empty && !reset;
    assign bus.id_inst  = reset ? '0 : buf_head.inst;
    assign bus.id_pc    = reset ? '0 : buf_head.pc;

    assign pcq_din = '{inst: '0, pc: pc};
    assign buf_din = '{inst: bus.imem_rsp_data,
                       pc:   pcq_head.pc};

    assign unused_pcq = ^{pcq_full, pcq_empty, pcq_count,
                          pcq_head.inst, buf_full};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pcq (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .pop   (rsp_keep),
        .flush (bus.redirect_valid),
        .din   (pcq_din),
        .dout  (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_keep),
        .pop   (id_fire),
        .flush (bus.redirect_valid),
        .din   (buf_din),
        .dout  (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_RESET;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire)
                         - CW'(bus.imem_rsp_valid);
            if (bus.redirect_valid) begin
                pc   <= align_pc(bus.redirect_pc);
                // every still-pending response belongs to the old path
                drop <= outstanding
                      - CW'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + PC_STEP;
                end
                if (bus.imem_rsp_valid && drop != '0) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a latency-programmable
// memory model and directed redirect/stall/reset scenarios.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;

    fetch_unit_if bus();

    fetch_unit #(
        .PC_RESET   (32'hFFFF_FFF8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int grant = 0;
    int used_cnt = 0;
    int lat = 1;
    int base = 0;
    logic stall = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int pend_due[$];
    logic [31:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(
        input logic [31:0] a
    );
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pcs(input logic [31:0] first,
                              input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(first + 32'(4 * i));
        grant += n;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            tick();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // memory: accepts while granted, answers in order after lat
    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (bus.imem_rsp_valid) begin
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    pend_addr.push_back(bus.imem_req_addr);
                    pend_due.push_back(cyc + lat);
                    used_cnt++;
                end
            end
            @(posedge clk);
            #2;
            if (!reset && pend_due.size() > 0
                && pend_due[0] <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = inst_of(pend_addr[0]);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
            bus.imem_req_ready = (used_cnt < grant) && !stall;
        end
    end

    // decode-side monitor
    always @(negedge clk) begin
        if (!reset && bus.id_valid && bus.id_ready
            && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL id_unexpected actual_pc=%h required=none",
                         bus.id_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("id_pc", bus.id_pc, mon_exp);
                chk("id_inst", bus.id_inst, inst_of(mon_exp));
            end
        end
    end

    initial begin
        reset              = 1'b1;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_id_valid", 32'(bus.id_valid), 0);
        chk("rst_id_inst", bus.id_inst, 0);
        chk("rst_id_pc", bus.id_pc, 0);

        // streaming across the 2^32 wrap
        tick();
        reset = 1'b0;
        lat = 1;
        bus.id_ready = 1'b1;
        expect_pcs(32'hFFFF_FFF8, 6);
        @(negedge clk);
        chk("A_first_valid", 32'(bus.imem_req_valid), 1);
        chk("A_first_addr", bus.imem_req_addr, 32'hFFFF_FFF8);
        drain("A_drain");
        @(negedge clk);
        chk("A_hold_valid", 32'(bus.imem_req_valid), 1);
        chk("A_hold_addr", bus.imem_req_addr, 32'h10);

        // decode back-pressure
        tick();
        bus.id_ready = 1'b0;
        base = used_cnt;
        expect_pcs(32'h10, 8);
        repeat (10) tick();
        chk("B_issued", 32'(used_cnt - base), 2);
        @(negedge clk);
        chk("B_req_valid", 32'(bus.imem_req_valid), 0);
        chk("B_pc_hold", bus.imem_req_addr, 32'h18);
        tick();
        bus.id_ready = 1'b1;
        drain("B_drain");

        // memory not ready
        stall = 1'b1;
        expect_pcs(32'h30, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("C_addr_stable", bus.imem_req_addr, 32'h30);
            chk("C_valid_held", 32'(bus.imem_req_valid), 1);
            tick();
        end
        stall = 1'b0;
        drain("C_drain");

        // redirect with two stale requests in flight
        lat = 3;
        base = used_cnt;
        grant += 2;
        for (int i = 0; i < 20 && used_cnt < base + 2; i++)
            tick();
        chk("D_issued", 32'(used_cnt - base), 2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        expect_pcs(32'h100, 2);
        @(negedge clk);
        chk("D_req_blocked", 32'(bus.imem_req_valid), 0);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("D_id_flushed", 32'(bus.id_valid), 0);
        tick();
        drain("D_drain");

        // misaligned redirect target
        lat = 1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        expect_pcs(32'h200, 2);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("E_addr_aligned", bus.imem_req_addr, 32'h200);
        chk("E_req_valid", 32'(bus.imem_req_valid), 1);
        tick();
        drain("E_drain");

        // redirect with a response and a decode pop in the same cycle
        lat = 2;
        bus.id_ready = 1'b0;
        grant += 2;
        for (int i = 0; i < 20 && !bus.id_valid; i++)
            tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        bus.id_ready       = 1'b1;
        expect_pcs(32'h300, 2);
        @(negedge clk);
        chk("F_head_valid", 32'(bus.id_valid), 1);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("F_id_flushed", 32'(bus.id_valid), 0);
        tick();
        drain("F_drain");

        // reset in the middle of buffered traffic
        lat = 1;
        bus.id_ready = 1'b0;
        grant += 2;
        repeat (5) tick();
        reset = 1'b1;
        @(negedge clk);
        chk("G_req_valid", 32'(bus.imem_req_valid), 0);
        chk("G_id_valid", 32'(bus.id_valid), 0);
        chk("G_id_inst", bus.id_inst, 0);
        chk("G_id_pc", bus.id_pc, 0);
        tick();
        reset = 1'b0;
        bus.id_ready = 1'b1;
        expect_pcs(32'hFFFF_FFF8, 3);
        @(negedge clk);
        chk("G_restart_addr", bus.imem_req_addr, 32'hFFFF_FFF8);
        chk("G_restart_valid", 32'(bus.imem_req_valid), 1);
        tick();
        drain("G_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the RV32I pipeline.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {instruction, PC} to decode, where the immediate generator and control decoder consume them.
- Handles branch/jump redirects by flushing buffered and in-flight instructions.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, instruction buffer entries; also the maximum of outstanding requests plus buffered entries (power of 2, ≥2)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address (current PC)
imem_rsp_valid  in  1  response valid; responses arrive in order, ≥1 cycle after acceptance
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  branch/jump taken, from execute
redirect_pc  in  32  new fetch target
id_valid  out  1  decode-side instruction valid
id_ready  in  1  decode accepts instruction
id_inst  out  32  instruction word to decode
id_pc  out  32  PC of id_inst

Behaviour:
- Reset (reset=1 at a clock edge):
  - pc=PC_RESET; FIFO empty; outstanding=0; drop=0.
  - Outputs while reset is asserted: imem_req_valid=0, id_valid=0, id_inst=0, id_pc=0.
  - Reset mid-operation discards everything. Responses to pre-reset requests arriving afterwards must be absent by system contract; they are not tracked.
- Credit:
  - Issue allowed when outstanding + fifo_count < FIFO_DEPTH.
  - imem_req_valid = credit_ok && !redirect_valid && !reset.
- Request handshake:
  - Fires when imem_req_valid && imem_req_ready.
  - On fire: pc <= pc+4 (mod 2^32); outstanding+1; push the request PC into an in-order PC queue (depth FIFO_DEPTH).
  - imem_req_addr = pc, held stable while valid and not ready.
- Response:
  - On imem_rsp_valid: outstanding-1; pop the PC queue.
  - If drop>0: drop-1, data discarded.
  - Otherwise: push {imem_rsp_data, popped PC} into the FIFO. Never overflows, guaranteed by the credit rule.
- Decode output:
  - id_valid = FIFO non-empty; id_inst/id_pc = FIFO head.
  - Pop on id_valid && id_ready.
  - Zero-bubble: response and pop in the same cycle are both honoured.
  - Latency: request accept at cycle N, response at N+k, id_valid at N+k+1.
- Redirect (redirect_valid=1 in cycle R):
  - pc <= {redirect_pc[31:2],2'b00}; FIFO cleared; PC queue cleared.
  - drop <= outstanding minus 1 if a response arrives in R (that response is also discarded).
  - A decode pop in R is ignored. id_valid=0 at R+1.
  - First new request presented at R+1.
- Simultaneous events:
  - Redirect in consecutive cycles: the last one wins.
  - Redirect while drop>0: drop recomputed from the current outstanding count, per the rule above.
- Back-pressure: while id_ready=0, the FIFO fills, issue stops once credit is exhausted, and the PC holds.

Decomposition:
- Package fetch_pkg: INST_W=32, XLEN=32, PC_STEP=4, typedef fetch_entry_t {logic[31:0] inst; logic[31:0] pc}.
- One natural sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH; push/pop/flush inputs; full/empty flags; count output.
  - Instantiated twice: instruction buffer, and PC queue (pc field only used).

Test Plan:
- Reset release, memory latency 1, id_ready=1 → requests at 0x0,0x4,0x8…; id_pc sequence 0x0,0x4,0x8 with matching id_inst, one per cycle after the first.
- id_ready=0 for 10 cycles → exactly FIFO_DEPTH(=2) requests issued; PC holds 0x8; after id_ready=1, stream resumes without loss or duplication.
- Two requests outstanding at latency 3, redirect_pc=0x100 → both stale responses dropped; first id_pc after redirect is 0x100.
- redirect_pc=0x203 → imem_req_addr=0x200.
- Redirect in the same cycle as a response and id pop → neither delivered; id_valid=0 next cycle.
- PC_RESET=32'hFFFF_FFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- imem_req_ready held low 5 cycles → imem_req_addr stable; no PC advance.
- Assert reset mid-stream → next cycle imem_req_valid=0 and id_valid=0; after release, fetch restarts at PC_RESET.
